// File: rtl/eq_pair_gen_if.sv
// Pair-stream bus between a host and the equal-pair stimulus generator.
// The master side issues requests; the slave side (the generator) drives the stream.
interface eq_pair_gen_if #(
    parameter int LEN_W  = 5,
    parameter int DATA_W = 16
);
    logic              start;
    logic [LEN_W-1:0]  run_len;
    logic [DATA_W-1:0] pattern;
    logic              busy;
    logic              a;
    logic              b;
    logic              valid;
    logic              z_exp;
    logic              done;

    modport master (
        output start, run_len, pattern,
        input  busy, a, b, valid, z_exp, done
    );

    modport slave (
        input  start, run_len, pattern,
        output busy, a, b, valid, z_exp, done
    );
endinterface

// File: rtl/eq_pair_gen.sv
// Emits a run of matching (a,b) pairs followed by one break pair, together
// with the registered response an equal-pair run detector should produce.
module eq_pair_gen #(
    parameter int LEN_W  = 5,
    parameter int DATA_W = 16,
    parameter int THRESH = 4
) (
    input  logic        Clk,
    input  logic        Rst,
    eq_pair_gen_if.slave bus
);
    localparam int MC_W = $clog2(THRESH + 1);

    typedef enum logic [1:0] {IDLE, RUN, BREAK, DONE} state_t;

    state_t            state, state_d;
    logic [LEN_W-1:0]  cnt, cnt_d;
    logic [DATA_W-1:0] shreg, shreg_d;
    logic [MC_W-1:0]   mcnt, mcnt_d;
    logic              busy_q, a_q, b_q, valid_q, z_q, done_q;
    logic              busy_d, a_d, b_d, valid_d, z_d, done_d;

    // The state register names the pair currently on the outputs, so cnt
    // holds the pairs still to come after the one being shown.
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        shreg_d = shreg;
        busy_d  = 1'b0;
        a_d     = 1'b0;
        b_d     = 1'b0;
        valid_d = 1'b0;
        done_d  = 1'b0;

        if (valid_q && (a_q == b_q))
            mcnt_d = (mcnt == MC_W'(THRESH)) ? mcnt : mcnt + MC_W'(1);
        else
            mcnt_d = '0;
        z_d = (mcnt_d == MC_W'(THRESH));

        case (state)
            IDLE: begin
                if (bus.start) begin
                    mcnt_d  = '0;
                    z_d     = 1'b0;
                    busy_d  = 1'b1;
                    valid_d = 1'b1;
                    if (bus.run_len != '0) begin
                        state_d = RUN;
                        a_d     = bus.pattern[0];
                        b_d     = bus.pattern[0];
                        shreg_d = {bus.pattern[0], bus.pattern[DATA_W-1:1]};
                        cnt_d   = bus.run_len - LEN_W'(1);
                    end else begin
                        state_d = BREAK;
                        a_d     = 1'b1;
                        shreg_d = bus.pattern;
                        cnt_d   = '0;
                    end
                end
            end
            RUN: begin
                busy_d  = 1'b1;
                valid_d = 1'b1;
                if (cnt != '0) begin
                    a_d     = shreg[0];
                    b_d     = shreg[0];
                    shreg_d = {shreg[0], shreg[DATA_W-1:1]};
                    cnt_d   = cnt - LEN_W'(1);
                end else begin
                    state_d = BREAK;
                    a_d     = 1'b1;
                end
            end
            BREAK: begin
                state_d = DONE;
                done_d  = 1'b1;
            end
            DONE: begin
                state_d = IDLE;
                mcnt_d  = '0;
                z_d     = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state   <= IDLE;
            cnt     <= '0;
            shreg   <= '0;
            mcnt    <= '0;
            busy_q  <= 1'b0;
            a_q     <= 1'b0;
            b_q     <= 1'b0;
            valid_q <= 1'b0;
            z_q     <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state   <= state_d;
            cnt     <= cnt_d;
            shreg   <= shreg_d;
            mcnt    <= mcnt_d;
            busy_q  <= busy_d;
            a_q     <= a_d;
            b_q     <= b_d;
            valid_q <= valid_d;
            z_q     <= z_d;
            done_q  <= done_d;
        end
    end

    assign bus.busy  = busy_q;
    assign bus.a     = a_q;
    assign bus.b     = b_q;
    assign bus.valid = valid_q;
    assign bus.z_exp = z_q;
    assign bus.done  = done_q;
endmodule

// File: tb/tb_eq_pair_gen.sv
// Bench for eq_pair_gen: a transaction-level model predicts every output cycle,
// and directed scenarios add hand-computed literal checks.
module tb_eq_pair_gen;
    localparam int LEN_W  = 5;
    localparam int DATA_W = 16;
    localparam int THRESH = 4;

    logic Clk;
    logic Rst;
    int   total;
    int   bad;

    eq_pair_gen_if #(.LEN_W(LEN_W), .DATA_W(DATA_W)) ifc ();

    eq_pair_gen #(.LEN_W(LEN_W), .DATA_W(DATA_W), .THRESH(THRESH)) dut (
        .Clk (Clk),
        .Rst (Rst),
        .bus (ifc)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Output vector order: {busy, a, b, valid, z_exp, done}
    logic [5:0] dv;
    assign dv = {ifc.busy, ifc.a, ifc.b, ifc.valid, ifc.z_exp, ifc.done};

    // Model: a accepted request expands into its full list of per-cycle outputs.
    logic [5:0] expq[$];
    logic [5:0] cur;
    bit         cur_busy;

    function automatic void push_txn(input int len, input logic [DATA_W-1:0] pat);
        logic [5:0] v;
        logic       bitv;
        logic       zz;
        for (int k = 1; k <= len; k++) begin
            bitv = pat[(k - 1) % DATA_W];
            zz   = (len >= THRESH) && (k >= THRESH + 1);
            v    = {1'b1, bitv, bitv, 1'b1, zz, 1'b0};
            expq.push_back(v);
        end
        zz = (len >= THRESH);
        v  = {1'b1, 1'b1, 1'b0, 1'b1, zz, 1'b0};
        expq.push_back(v);
        expq.push_back(6'b000001);
    endfunction

    always @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            expq.delete();
            cur      = '0;
            cur_busy = 1'b0;
        end else begin
            if (!cur_busy && ifc.start)
                push_txn(int'(ifc.run_len), ifc.pattern);
            if (expq.size() > 0) begin
                cur      = expq.pop_front();
                cur_busy = 1'b1;
            end else begin
                cur      = '0;
                cur_busy = 1'b0;
            end
        end
    end

    logic [5:0] cap [1:24];
    logic [5:0] norm_exp [1:8];
    logic [5:0] v;
    logic [5:0] zm;
    int         na;
    int         nz;

    task automatic step(output logic [5:0] got);
        @(negedge Clk);
        total++;
        if (dv !== cur) begin
            bad++;
            $display("FAIL cycle_model t=%0t got=%b want=%b", $time, dv, cur);
        end
        got = dv;
    endtask

    task automatic chk(input string name, input logic [5:0] got, input logic [5:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%b want=%b", name, got, want);
        end
    endtask

    task automatic pulse(input int len, input logic [DATA_W-1:0] pat);
        #1;
        ifc.start   = 1'b1;
        ifc.run_len = LEN_W'(len);
        ifc.pattern = pat;
    endtask

    task automatic capture(input int n, input int repulse_k);
        for (int k = 1; k <= n; k++) begin
            step(cap[k]);
            if (k == 1 || k == repulse_k + 1) begin
                #1 ifc.start = 1'b0;
            end
            if (k == repulse_k) begin
                #1;
                ifc.start   = 1'b1;
                ifc.run_len = LEN_W'(2);
                ifc.pattern = '0;
            end
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        norm_exp = '{6'b111100, 6'b100100, 6'b111100, 6'b100100,
                     6'b100110, 6'b111110, 6'b110110, 6'b000001};
        Rst         = 1'b1;
        ifc.start   = 1'b0;
        ifc.run_len = '0;
        ifc.pattern = '0;
        step(v);
        step(v);
        chk("reset_state", v, 6'b000000);
        #1 Rst = 1'b0;
        repeat (2) step(v);

        // Normal run
        pulse(6, 16'h00A5);
        capture(8, 0);
        for (int k = 1; k <= 8; k++)
            chk($sformatf("normal_k%0d", k), cap[k], norm_exp[k]);
        repeat (2) step(v);

        // Short run: no z, break at 4, done at 5
        pulse(3, 16'hFFFF);
        capture(6, 0);
        zm = '0;
        for (int k = 1; k <= 6; k++) zm[k-1] = cap[k][1];
        chk("short_z", zm, 6'b000000);
        chk("short_brk", cap[4], 6'b110100);
        chk("short_done", cap[5], 6'b000001);
        step(v);

        // Zero length
        pulse(0, 16'hFFFF);
        capture(3, 0);
        chk("zero_brk", cap[1], 6'b110100);
        chk("zero_done", cap[2], 6'b000001);
        chk("zero_idle", cap[3], 6'b000000);
        step(v);

        // Wrap past DATA_W
        pulse(20, 16'h0001);
        capture(23, 0);
        na = 0;
        nz = 0;
        for (int k = 1; k <= 23; k++) begin
            if (cap[k][4] && cap[k][3] && cap[k][2]) na++;
            if (cap[k][1]) nz++;
        end
        chk("wrap_ones", 6'(na), 6'd2);
        chk("wrap_pair17", cap[17], 6'b111110);
        chk("wrap_zcount", 6'(nz), 6'd17);
        chk("wrap_z5", cap[5], 6'b100110);
        chk("wrap_done", cap[22], 6'b000001);
        step(v);

        // Start while busy is ignored
        pulse(6, 16'h00A5);
        capture(10, 3);
        for (int k = 1; k <= 8; k++)
            chk($sformatf("busy_k%0d", k), cap[k], norm_exp[k]);
        chk("busy_idle", cap[10], 6'b000000);

        // Asynchronous reset mid-RUN
        pulse(6, 16'hFFFF);
        capture(3, 0);
        @(posedge Clk);
        #2 Rst = 1'b1;
        #1 chk("rst_async", dv, 6'b000000);
        step(v);
        step(v);
        #1 Rst = 1'b0;
        step(v);
        pulse(4, 16'h000F);
        capture(7, 0);
        zm = '0;
        for (int k = 1; k <= 6; k++) zm[k-1] = cap[k][1];
        chk("rst_after_z", zm, 6'b010000);
        chk("rst_after_done", cap[6], 6'b000001);
        repeat (3) step(v);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/eq_pair_gen.md
Name: eq_pair_gen

Overview:
- Stimulus/transmit side of the equal-pair run detector: serially drives an (a,b) pair stream containing a programmed run of matching pairs (a==b), then one mismatching break pair.
- Carries an internal model of the detector and outputs the expected detector response `z_exp` cycle-aligned with the stream.
- Sits in front of the detector in practice benches and the FSM demo top; a host pulses `start` with a run length and a bit pattern.

Parameters:
- LEN_W, 5, width of run_len and internal run counter.
- DATA_W, 16, width of pattern shift register.
- THRESH, 4, consecutive matching pairs after which detector output is expected high.

Ports:
- Clk  in  1  clock, rising edge
- Rst  in  1  reset, asynchronous, active-high
- start  in  1  request; sampled only in IDLE
- run_len  in  LEN_W  number of matching pairs to emit (0 legal)
- pattern  in  DATA_W  value for a (=b) per pair, LSB first
- busy  out  1  transfer in progress
- a  out  1  pair bit a
- b  out  1  pair bit b
- valid  out  1  a/b carry a meaningful pair this cycle
- z_exp  out  1  expected detector z this cycle
- done  out  1  one-cycle completion pulse

Behaviour:
- All outputs registered.
- Rst asserted (async, any state, including mid-RUN): state=IDLE; busy=a=b=valid=z_exp=done=0; counters and shift register cleared. Outputs go low without waiting for Clk.
- States: IDLE, RUN, BREAK, DONE.
- IDLE:
  - start=1 at edge T0 latches run_len into cnt, pattern into shreg, clears match counter mcnt.
  - Next state is RUN if run_len!=0, else BREAK.
  - start=0 holds IDLE with all outputs 0.
- RUN:
  - Pair k (1-based) visible in cycle T0+k: a=b=pattern bit ((k-1) mod DATA_W).
  - shreg rotates right by 1 each pair, so run_len>DATA_W wraps to bit 0.
  - valid=1, busy=1.
  - RUN lasts exactly run_len cycles, then BREAK.
- BREAK: one cycle, T0+run_len+1: a=1, b=0, valid=1, busy=1; then DONE.
- DONE: one cycle, T0+run_len+2: done=1, busy=0, valid=0, a=b=0; then IDLE. The earliest new start is sampled in cycle T0+run_len+3.
- start while not in IDLE: ignored; run_len/pattern changes after T0 have no effect.
- z_exp model, matching the detector's registered output:
  - mcnt counts consecutive emitted matching pairs, saturating at THRESH.
  - z_exp in cycle n+1 = 1 iff the pair in cycle n was matching and mcnt reached THRESH with that pair.
  - For run_len>=THRESH, z_exp=1 in cycles T0+THRESH+1 through T0+run_len+1 inclusive (the last is the BREAK cycle).
  - z_exp=0 in the DONE cycle and all other cycles.
  - For run_len<THRESH, z_exp never asserts.
- valid=0 cycles never advance mcnt; mcnt resets on break and on IDLE entry.

Test Plan:
- Normal run: Rst pulse, then start with run_len=6, pattern=0x00A5.
  - Cycles T0+1..T0+6: a=b=1,0,1,0,0,1.
  - T0+7: a=1, b=0.
  - z_exp=1 in T0+5..T0+7.
  - done=1 at T0+8; busy=1 in T0+1..T0+7.
- Short run: run_len=3 → three matching pairs, break at T0+4, z_exp stays 0, done at T0+5.
- Zero length: run_len=0 → T0+1 break pair only, valid=1 for that cycle only, done at T0+2, z_exp=0.
- Wrap: run_len=20, pattern=0x0001.
  - a=b=1 at pairs 1 and 17, 0 elsewhere.
  - z_exp=1 in T0+5..T0+21; done at T0+22.
- Busy and reset:
  - start re-pulsed at T0+3 of a run_len=6 transfer → ignored, timing unchanged.
  - Rst asserted mid-RUN (between edges) → all outputs 0 immediately.
  - After release, a new start with run_len=4 gives z_exp=1 only in T0'+5.
